// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: pointer Gray/binary conversion and default sizing.
// Used by both the read-side and write-side pointer controllers.
package async_fifo_pkg;

   localparam int DEFAULT_ADDR_WIDTH  = 3;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Conversions work on a zero-extended word so any pointer up to
   // PTR_MAX_W bits (ADDR_WIDTH+1) can be passed through and sliced back.
   localparam int PTR_MAX_W = 16;
   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// N-stage plain flop synchroniser for a Gray-coded pointer crossing clock domains.
// No logic sits between stages so each bit sees only flop-to-flop paths.
module async_fifo_ptr_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] stage_d;
         logic [WIDTH-1:0] stage_q;

         if (gi == 0) begin : g_first
            assign stage_d = d;
         end else begin : g_chain
            assign stage_d = g_stage[gi-1].stage_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stage_q <= '0;
            end else begin
               stage_q <= stage_d;
            end
         end
      end
   endgenerate

   assign q = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/async_fifo_rd.sv
// Async FIFO read-domain controller: read pointers, write-pointer synchroniser, empty flag.
// Optional rd_level output enabled by defining ASYNC_FIFO_RD_LEVEL_EN.
module async_fifo_rd
   import async_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic                  rd_inc,
   input  logic [ADDR_WIDTH:0]   gray_wr_ptr,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   gray_rd_ptr,
`ifdef ASYNC_FIFO_RD_LEVEL_EN
   output logic                  rd_empty,
   output logic [ADDR_WIDTH:0]   rd_level
`else
   output logic                  rd_empty
`endif
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
   logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
   logic             rd_empty_q, rd_empty_d;
   logic             rd_pop;
   logic [PTR_W-1:0] wr_gray_sync;

   async_fifo_ptr_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wr_ptr_sync (
      .clk   (R_CLK),
      .rst_n (R_RST),
      .d     (gray_wr_ptr),
      .q     (wr_gray_sync)
   );

   // Empty compares the post-pop pointer so the last pop raises the flag on its own edge.
   always_comb begin
      rd_pop     = rd_inc & ~rd_empty_q;
      rd_bin_d   = rd_bin_q + PTR_W'(rd_pop);
      rd_gray_d  = PTR_W'(bin2gray(PTR_MAX_W'(rd_bin_d)));
      rd_empty_d = (rd_gray_d == wr_gray_sync);
   end

   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
         rd_bin_q   <= '0;
         rd_gray_q  <= '0;
         rd_empty_q <= 1'b1;
      end else begin
         rd_bin_q   <= rd_bin_d;
         rd_gray_q  <= rd_gray_d;
         rd_empty_q <= rd_empty_d;
      end
   end

   assign rd_addr     = rd_bin_q[ADDR_WIDTH-1:0];
   assign gray_rd_ptr = rd_gray_q;
   assign rd_empty    = rd_empty_q;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
   logic [PTR_W-1:0] wr_bin_sync;

   assign wr_bin_sync = PTR_W'(gray2bin(PTR_MAX_W'(wr_gray_sync)));
   assign rd_level    = wr_bin_sync - rd_bin_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd.sv
// Directed self-checking bench for async_fifo_rd (level checks when ASYNC_FIFO_RD_LEVEL_EN is set).
module tb_async_fifo_rd;

   localparam int AW = 3;

   logic          R_CLK = 1'b0;
   logic          R_RST;
   logic          rd_inc;
   logic [AW:0]   gray_wr_ptr;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   gray_rd_ptr;
   logic          rd_empty;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
   logic [AW:0]   rd_level;
`endif

   int checks   = 0;
   int failures = 0;

   logic [3:0] fill_gray [8]  = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100};
   // Gray codes of binary 9..24 (mod 16): continues on from pointer 8.
   logic [3:0] wrap_gray [16] = '{4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000,
                                  4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100};

   always #5 R_CLK = ~R_CLK;

   async_fifo_rd #(
      .ADDR_WIDTH  (AW),
      .SYNC_STAGES (2)
   ) dut (
      .R_CLK       (R_CLK),
      .R_RST       (R_RST),
      .rd_inc      (rd_inc),
      .gray_wr_ptr (gray_wr_ptr),
      .rd_addr     (rd_addr),
      .gray_rd_ptr (gray_rd_ptr),
`ifdef ASYNC_FIFO_RD_LEVEL_EN
      .rd_empty    (rd_empty),
      .rd_level    (rd_level)
`else
      .rd_empty    (rd_empty)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge R_CLK);
      #1;
   endtask

   task automatic apply_reset();
      rd_inc      = 1'b0;
      gray_wr_ptr = '0;
      R_RST       = 1'b0;
      tick(2);
      R_RST       = 1'b1;
   endtask

   initial begin
      logic [3:0] prev_gray;

      // Reset state and ignored pops while empty
      apply_reset();
      check_val("rst_empty", 32'(rd_empty), 32'd1);
      check_val("rst_addr",  32'(rd_addr), 32'd0);
      check_val("rst_gray",  32'(gray_rd_ptr), 32'd0);
      rd_inc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val($sformatf("empty_pop%0d_gray", i), 32'(gray_rd_ptr), 32'd0);
         check_val($sformatf("empty_pop%0d_addr", i), 32'(rd_addr), 32'd0);
         check_val($sformatf("empty_pop%0d_flag", i), 32'(rd_empty), 32'd1);
      end
      rd_inc = 1'b0;

      // Write-to-read latency and single pop
      gray_wr_ptr = 4'b0001;
      tick();
      check_val("lat_edge1_empty", 32'(rd_empty), 32'd1);
      tick();
      check_val("lat_edge2_empty", 32'(rd_empty), 32'd1);
      tick();
      check_val("lat_edge3_empty", 32'(rd_empty), 32'd0);
      check_val("lat_addr", 32'(rd_addr), 32'd0);
      rd_inc = 1'b1;
      tick();
      rd_inc = 1'b0;
      check_val("pop1_empty", 32'(rd_empty), 32'd1);
      check_val("pop1_gray",  32'(gray_rd_ptr), 32'b0001);
      check_val("pop1_addr",  32'(rd_addr), 32'd1);

      // Full FIFO drained with 8 back-to-back pops
      apply_reset();
      gray_wr_ptr = 4'b1100;
      tick(3);
      check_val("full_empty", 32'(rd_empty), 32'd0);
`ifdef ASYNC_FIFO_RD_LEVEL_EN
      check_val("full_level", 32'(rd_level), 32'd8);
`endif
      rd_inc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("drain%0d_addr", i), 32'(rd_addr), 32'(i));
         tick();
         check_val($sformatf("drain%0d_gray", i), 32'(gray_rd_ptr), 32'(fill_gray[i]));
         check_val($sformatf("drain%0d_empty", i), 32'(rd_empty), (i == 7) ? 32'd1 : 32'd0);
      end
      rd_inc = 1'b0;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
      check_val("drained_level", 32'(rd_level), 32'd0);
`endif

      // Wrap: 16 write/pop pairs starting from pointer 8
      prev_gray = gray_rd_ptr;
      for (int i = 0; i < 16; i++) begin
         gray_wr_ptr = wrap_gray[i];
         tick(3);
         check_val($sformatf("wrap%0d_ready", i), 32'(rd_empty), 32'd0);
         rd_inc = 1'b1;
         tick();
         rd_inc = 1'b0;
         check_val($sformatf("wrap%0d_gray", i), 32'(gray_rd_ptr), 32'(wrap_gray[i]));
         check_val($sformatf("wrap%0d_addr", i), 32'(rd_addr), 32'((9 + i) % 8));
         check_val($sformatf("wrap%0d_empty", i), 32'(rd_empty), 32'd1);
         check_val($sformatf("wrap%0d_onebit", i), 32'($countones(prev_gray ^ gray_rd_ptr)), 32'd1);
         prev_gray = gray_rd_ptr;
      end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
      // Occupancy from synchronised write pointer
      apply_reset();
      gray_wr_ptr = 4'b0110;
      tick(3);
      rd_inc = 1'b1;
      tick();
      rd_inc = 1'b0;
      check_val("level_after_pop1", 32'(rd_level), 32'd3);
      rd_inc = 1'b1;
      tick();
      rd_inc = 1'b0;
      check_val("level_after_pop2", 32'(rd_level), 32'd2);
`endif

      // Asynchronous reset mid-burst
      apply_reset();
      gray_wr_ptr = 4'b1100;
      tick(3);
      rd_inc = 1'b1;
      tick(3);
      check_val("burst3_gray", 32'(gray_rd_ptr), 32'b0010);
      check_val("burst3_addr", 32'(rd_addr), 32'd3);
      R_RST = 1'b0;
      #2;
      check_val("async_rst_gray",  32'(gray_rd_ptr), 32'd0);
      check_val("async_rst_addr",  32'(rd_addr), 32'd0);
      check_val("async_rst_empty", 32'(rd_empty), 32'd1);
      rd_inc = 1'b0;
      tick();
      R_RST = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
